// File: rtl/cmd_seq_ctrl.sv
// Command sequencer: queues fixed-width commands, sends them MSB byte first to a
// UART transmitter and waits for a one-byte response with a per-wait timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing in flight, waiting for a queued command
// LOAD      | pop queue head into the shift register
// SEND      | present one byte on tx_data, strobe trmt
// WAIT_TX   | wait for tx_done rising edge
// WAIT_RESP | wait for a response byte or timeout
module cmd_seq_ctrl #(
    parameter int          DEPTH        = 4,
    parameter int          CMD_BYTES    = 2,
    parameter int          TIMEOUT_CLKS = 100000,
    parameter logic [7:0]  RESP_CMPLT   = 8'hA5,
    parameter logic [7:0]  RESP_INTER   = 8'h5A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [8*CMD_BYTES-1:0]   cmd_in,
    input  logic                     cmd_push,
    input  logic                     abort,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               tx_data,
    output logic                     trmt,
    input  logic                     tx_done,
    input  logic [7:0]               rx_data,
    input  logic                     rx_rdy,
    output logic                     clr_rx_rdy,
    output logic                     busy,
    output logic                     cmd_done,
    output logic                     resp_err,
    output logic                     timeout,
    output logic                     ovf,
    output logic [7:0]               last_resp
);

    localparam int CMD_W = 8 * CMD_BYTES;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int TW    = $clog2(TIMEOUT_CLKS + 1);
    localparam int IW    = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [IW-1:0] IDX_TOP  = IW'(CMD_BYTES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] SEND      = 3'd2;
    localparam logic [2:0] WAIT_TX   = 3'd3;
    localparam logic [2:0] WAIT_RESP = 3'd4;

    logic [2:0]       state;
    logic [CMD_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [CMD_W-1:0] head, shreg;
    logic [IW-1:0]    idx;
    logic [TW-1:0]    tmo_cnt;
    logic             tx_done_q;
    logic             tx_rise, push_ok, pop;

    assign head       = mem[rd_ptr];
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = cmd_push && !full && !abort;
    assign pop        = (state == LOAD) && !abort;
    assign tx_rise    = tx_done && !tx_done_q;
    assign busy       = (state != IDLE);
    assign trmt       = (state == SEND) && !abort;
    assign clr_rx_rdy = (state == WAIT_RESP) && rx_rdy && !abort;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tx_done_q <= 1'b0;
        else
            tx_done_q <= tx_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            tmo_cnt   <= '0;
            tx_data   <= 8'h00;
            last_resp <= 8'h00;
            cmd_done  <= 1'b0;
            resp_err  <= 1'b0;
            timeout   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            resp_err <= 1'b0;
            timeout  <= 1'b0;
            ovf      <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                idx     <= '0;
                tmo_cnt <= '0;
            end else begin
                // a push into a full queue is lost even if LOAD pops this cycle
                ovf <= cmd_push && full;
                case (state)
                    IDLE: begin
                        if (!empty)
                            state <= LOAD;
                    end
                    LOAD: begin
                        tx_data <= head[CMD_W-1 -: 8];
                        shreg   <= head << 8;
                        idx     <= IDX_TOP;
                        state   <= SEND;
                    end
                    SEND: begin
                        state <= WAIT_TX;
                    end
                    WAIT_TX: begin
                        if (tx_rise) begin
                            if (idx != '0) begin
                                idx     <= idx - IW'(1);
                                tx_data <= shreg[CMD_W-1 -: 8];
                                shreg   <= shreg << 8;
                                state   <= SEND;
                            end else begin
                                tmo_cnt <= '0;
                                state   <= WAIT_RESP;
                            end
                        end
                    end
                    WAIT_RESP: begin
                        // a response arriving on the expiry cycle wins over the timeout
                        if (rx_rdy) begin
                            last_resp <= rx_data;
                            if (rx_data == RESP_INTER) begin
                                tmo_cnt <= '0;
                            end else if (rx_data == RESP_CMPLT) begin
                                cmd_done <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                resp_err <= 1'b1;
                                state    <= IDLE;
                            end
                        end else if (tmo_cnt == TMO_LAST) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else if (tmo_cnt != {TW{1'b1}}) begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_seq_ctrl.sv
// Directed bench for cmd_seq_ctrl: a small UART stand-in acknowledges each trmt,
// and each task drives one scenario and checks it against hand-computed values.
module tb_cmd_seq_ctrl;

    localparam int DEPTH     = 4;
    localparam int CMD_BYTES = 2;
    localparam int T         = 40;

    logic        clk, rst_n;
    logic [15:0] cmd_in;
    logic        cmd_push, abort;
    logic        full, empty;
    logic [7:0]  tx_data;
    logic        trmt, tx_done;
    logic [7:0]  rx_data;
    logic        rx_rdy, clr_rx_rdy, busy;
    logic        cmd_done, resp_err, timeout, ovf;
    logic [7:0]  last_resp;

    int tests, fails, cyc;
    int nb, cmd_done_n, resp_err_n, timeout_n, ovf_n, clr_n, tmo_delta, last_txd_cyc;
    logic [7:0] log_b [64];
    int         log_c [64];
    bit         auto_tx;

    cmd_seq_ctrl #(
        .DEPTH(DEPTH), .CMD_BYTES(CMD_BYTES), .TIMEOUT_CLKS(T),
        .RESP_CMPLT(8'hA5), .RESP_INTER(8'h5A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_push(cmd_push), .abort(abort),
        .full(full), .empty(empty), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .busy(busy),
        .cmd_done(cmd_done), .resp_err(resp_err), .timeout(timeout), .ovf(ovf),
        .last_resp(last_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // UART transmitter stand-in: tx_done rises two cycles after each trmt
    initial begin
        int tx_cnt;
        tx_cnt  = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done      = 1'b1;
                    last_txd_cyc = cyc + 1;
                end
            end else if (trmt && auto_tx) begin
                tx_cnt = 2;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (trmt) begin
                if (nb < 64) begin
                    log_b[nb] = tx_data;
                    log_c[nb] = cyc;
                end
                nb++;
            end
            if (cmd_done)   cmd_done_n++;
            if (resp_err)   resp_err_n++;
            if (ovf)        ovf_n++;
            if (clr_rx_rdy) clr_n++;
            if (timeout) begin
                timeout_n++;
                tmo_delta = cyc - last_txd_cyc;
            end
        end
    end

    task clear_counts();
        nb = 0; cmd_done_n = 0; resp_err_n = 0; timeout_n = 0;
        ovf_n = 0; clr_n = 0; tmo_delta = -1;
    endtask

    task push(input logic [15:0] c);
        @(negedge clk);
        cmd_in   = c;
        cmd_push = 1'b1;
        @(negedge clk);
        cmd_push = 1'b0;
    endtask

    task send_resp(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task wait_bytes(input int n);
        int k;
        k = 0;
        while (nb < n && k < 300) begin
            @(negedge clk);
            #3;
            k++;
        end
        tests++;
        if (nb < n) begin
            fails++;
            $display("FAIL wait_bytes: got %0d bytes, want %0d", nb, n);
        end
    endtask

    task test_reset();
        #12;
        tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
        tests++; if (full !== 1'b0)    begin fails++; $display("FAIL reset_full: got %b want 0", full); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        tests++; if (last_resp !== 8'h00) begin fails++; $display("FAIL reset_last_resp: got %h want 00", last_resp); end
        tests++; if ({trmt, clr_rx_rdy, cmd_done, resp_err, timeout, ovf} !== 6'b0)
            begin fails++; $display("FAIL reset_pulses: got %b want 000000", {trmt, clr_rx_rdy, cmd_done, resp_err, timeout, ovf}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task test_rx_ignored();
        @(negedge clk);
        rx_data = 8'hA5;
        rx_rdy  = 1'b1;
        #2;
        tests++; if (clr_rx_rdy !== 1'b0) begin fails++; $display("FAIL idle_rx_clr: got %b want 0", clr_rx_rdy); end
        @(negedge clk);
        rx_rdy = 1'b0;
        #2;
        tests++; if (last_resp !== 8'h00) begin fails++; $display("FAIL idle_rx_last_resp: got %h want 00", last_resp); end
    endtask

    task test_basic();
        int push_cyc;
        clear_counts();
        auto_tx = 1'b1;
        @(negedge clk);
        cmd_in   = 16'h1234;
        cmd_push = 1'b1;
        push_cyc = cyc;
        @(negedge clk);
        cmd_push = 1'b0;
        wait_bytes(2);
        repeat (5) @(negedge clk);
        send_resp(8'hA5);
        repeat (2) @(negedge clk);
        #3;
        tests++; if (log_c[0] !== push_cyc + 3) begin fails++; $display("FAIL basic_latency: trmt at cycle %0d want %0d", log_c[0], push_cyc + 3); end
        tests++; if (log_b[0] !== 8'h12) begin fails++; $display("FAIL basic_byte0: got %h want 12", log_b[0]); end
        tests++; if (log_b[1] !== 8'h34) begin fails++; $display("FAIL basic_byte1: got %h want 34", log_b[1]); end
        tests++; if (nb !== 2) begin fails++; $display("FAIL basic_nbytes: got %0d want 2", nb); end
        tests++; if (cmd_done_n !== 1) begin fails++; $display("FAIL basic_cmd_done: got %0d want 1", cmd_done_n); end
        tests++; if (clr_n !== 1) begin fails++; $display("FAIL basic_clr: got %0d want 1", clr_n); end
        tests++; if (last_resp !== 8'hA5) begin fails++; $display("FAIL basic_last_resp: got %h want a5", last_resp); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task test_inter();
        logic [7:0] r [3];
        r[0] = 8'h5A; r[1] = 8'h5A; r[2] = 8'hA5;
        clear_counts();
        push(16'hABCD);
        wait_bytes(2);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            repeat (T - 11) @(negedge clk);
            send_resp(r[i]);
        end
        repeat (2) @(negedge clk);
        #3;
        tests++; if (timeout_n !== 0) begin fails++; $display("FAIL inter_timeout: got %0d want 0", timeout_n); end
        tests++; if (cmd_done_n !== 1) begin fails++; $display("FAIL inter_cmd_done: got %0d want 1", cmd_done_n); end
        tests++; if (clr_n !== 3) begin fails++; $display("FAIL inter_clr: got %0d want 3", clr_n); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL inter_busy: got %b want 0", busy); end
    endtask

    task test_timeout();
        int k;
        clear_counts();
        push(16'h1111);
        push(16'h2233);
        k = 0;
        while (timeout_n == 0 && k < 300) begin
            @(negedge clk);
            #3;
            k++;
        end
        tests++; if (timeout_n !== 1) begin fails++; $display("FAIL tmo_pulse: got %0d want 1", timeout_n); end
        tests++; if (tmo_delta !== T) begin fails++; $display("FAIL tmo_delay: got %0d want %0d", tmo_delta, T); end
        tests++; if (cmd_done_n !== 0) begin fails++; $display("FAIL tmo_cmd_done: got %0d want 0", cmd_done_n); end
        wait_bytes(4);
        tests++; if (log_b[2] !== 8'h22 || log_b[3] !== 8'h33)
            begin fails++; $display("FAIL tmo_next_cmd: got %h%h want 2233", log_b[2], log_b[3]); end
        repeat (5) @(negedge clk);
        send_resp(8'hA5);
        repeat (2) @(negedge clk);
        #3;
        tests++; if (cmd_done_n !== 1 || timeout_n !== 1)
            begin fails++; $display("FAIL tmo_second_done: got done=%0d tmo=%0d want 1 1", cmd_done_n, timeout_n); end
    endtask

    task test_coincident();
        int entry;
        clear_counts();
        push(16'h4455);
        wait_bytes(2);
        repeat (4) @(negedge clk);
        entry = last_txd_cyc;
        while (cyc < entry + T - 1) @(negedge clk);
        rx_data = 8'hA5;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        tests++; if (timeout_n !== 0) begin fails++; $display("FAIL coinc_timeout: got %0d want 0", timeout_n); end
        tests++; if (cmd_done_n !== 1) begin fails++; $display("FAIL coinc_cmd_done: got %0d want 1", cmd_done_n); end
    endtask

    task test_resp_err();
        clear_counts();
        push(16'h0F0F);
        wait_bytes(2);
        repeat (5) @(negedge clk);
        send_resp(8'h3C);
        repeat (2) @(negedge clk);
        #3;
        tests++; if (resp_err_n !== 1) begin fails++; $display("FAIL err_pulse: got %0d want 1", resp_err_n); end
        tests++; if (cmd_done_n !== 0) begin fails++; $display("FAIL err_cmd_done: got %0d want 0", cmd_done_n); end
        tests++; if (last_resp !== 8'h3C) begin fails++; $display("FAIL err_last_resp: got %h want 3c", last_resp); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL err_busy: got %b want 0", busy); end
    endtask

    task test_ovf();
        clear_counts();
        push(16'hAAAA);
        wait_bytes(2);
        repeat (5) @(negedge clk);
        for (int i = 0; i < DEPTH + 1; i++) begin
            @(negedge clk);
            cmd_in   = 16'h0102 + 16'(i) * 16'h0202;
            cmd_push = 1'b1;
        end
        @(negedge clk);
        cmd_push = 1'b0;
        #3;
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b want 1", full); end
        tests++; if (ovf_n !== 1) begin fails++; $display("FAIL ovf_pulse: got %0d want 1", ovf_n); end
        send_resp(8'hA5);
        for (int j = 1; j <= DEPTH; j++) begin
            wait_bytes(2 + 2 * j);
            repeat (5) @(negedge clk);
            send_resp(8'hA5);
        end
        repeat (3) @(negedge clk);
        #3;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            tests++;
            if (log_b[2 + k] !== 8'(k + 1)) begin
                fails++;
                $display("FAIL ovf_order byte %0d: got %h want %h", k, log_b[2 + k], 8'(k + 1));
            end
        end
        tests++; if (nb !== 2 + 2 * DEPTH) begin fails++; $display("FAIL ovf_nbytes: got %0d want %0d", nb, 2 + 2 * DEPTH); end
        tests++; if (cmd_done_n !== DEPTH + 1) begin fails++; $display("FAIL ovf_cmd_done: got %0d want %0d", cmd_done_n, DEPTH + 1); end
        tests++; if (empty !== 1'b1 || ovf_n !== 1) begin fails++; $display("FAIL ovf_final: got empty=%b ovf=%0d want 1 1", empty, ovf_n); end
    endtask

    task test_abort();
        clear_counts();
        auto_tx = 1'b0;
        push(16'hC0DE);
        wait_bytes(1);
        for (int i = 0; i < 3; i++) push(16'h1000 + 16'(i));
        #3;
        tests++; if (empty !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL abort_pre: got empty=%b busy=%b want 0 1", empty, busy); end
        @(negedge clk);
        abort    = 1'b1;
        cmd_push = 1'b1;
        cmd_in   = 16'hDEAD;
        @(negedge clk);
        abort    = 1'b0;
        cmd_push = 1'b0;
        #3;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL abort_empty: got empty=%b full=%b want 1 0", empty, full); end
        repeat (20) @(negedge clk);
        #3;
        tests++; if (nb !== 1 || empty !== 1'b1) begin fails++; $display("FAIL abort_no_trmt: got bytes=%0d empty=%b want 1 1", nb, empty); end
        tests++; if (cmd_done_n + resp_err_n + timeout_n + ovf_n !== 0)
            begin fails++; $display("FAIL abort_pulses: got %0d want 0", cmd_done_n + resp_err_n + timeout_n + ovf_n); end
        auto_tx = 1'b1;
    endtask

    task test_reset_mid();
        clear_counts();
        push(16'h7788);
        wait_bytes(1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || trmt !== 1'b0 || tx_data !== 8'h00)
            begin fails++; $display("FAIL rstmid_async: got busy=%b trmt=%b tx=%h want 0 0 00", busy, trmt, tx_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #3;
        tests++; if (nb !== 1 || empty !== 1'b1 || busy !== 1'b0)
            begin fails++; $display("FAIL rstmid_abandon: got bytes=%0d empty=%b busy=%b want 1 1 0", nb, empty, busy); end
        tests++; if (cmd_done_n + resp_err_n + timeout_n + ovf_n !== 0)
            begin fails++; $display("FAIL rstmid_pulses: got %0d want 0", cmd_done_n + resp_err_n + timeout_n + ovf_n); end
    endtask

    initial begin
        tests = 0; fails = 0; last_txd_cyc = 0;
        rst_n = 1'b0; cmd_in = 16'h0; cmd_push = 1'b0; abort = 1'b0;
        rx_data = 8'h00; rx_rdy = 1'b0; auto_tx = 1'b0;
        clear_counts();
        test_reset();
        test_rx_ignored();
        test_basic();
        test_inter();
        test_timeout();
        test_coincident();
        test_resp_err();
        test_ovf();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
